// File: rtl/lc3b_types.sv
// Shared LC-3b types for the memory subsystem.
// Word, byte-mask and arbiter state encodings.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_A,
    ARB_SERVE_B
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one physical memory port between fetch (A) and MEM stage (B).
// B has priority; a starvation counter forces an A grant when needed.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          read_a,
  input  lc3b_word      address_a,
  output logic          resp_a,
  output lc3b_word      rdata_a,
  input  logic          read_b,
  input  logic          write_b,
  input  lc3b_word      address_b,
  input  lc3b_word      wdata_b,
  input  lc3b_mem_wmask wmask_b,
  output logic          resp_b,
  output lc3b_word      rdata_b,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_wmask,
  input  logic          pmem_resp,
  input  lc3b_word      pmem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t    state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  lc3b_word      addr_q, addr_d;
  lc3b_word      wdata_q, wdata_d;
  lc3b_mem_wmask wmask_q, wmask_d;
  logic          wr_q, wr_d;

  logic req_b, grant_b, grant_a;
  logic serve_a, serve_b;

  assign req_b   = read_b | write_b;
  assign grant_b = req_b & (~read_a | (starve_q < LIMIT));
  assign grant_a = read_a & ~grant_b;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    wr_d     = wr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_b) begin
          state_d = ARB_SERVE_B;
          addr_d  = address_b;
          wdata_d = wdata_b;
          wmask_d = wmask_b;
          wr_d    = write_b;
          // grant_b with read_a implies starve_q < LIMIT
          if (read_a) starve_d = starve_q + 4'd1;
        end else if (grant_a) begin
          state_d  = ARB_SERVE_A;
          addr_d   = address_a;
          wr_d     = 1'b0;
          starve_d = 4'd0;
        end
      end
      ARB_SERVE_A, ARB_SERVE_B: begin
        if (pmem_resp) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      starve_q <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      wr_q     <= wr_d;
    end
  end

  assign serve_a = (state_q == ARB_SERVE_A);
  assign serve_b = (state_q == ARB_SERVE_B);

  assign pmem_read    = serve_a | (serve_b & ~wr_q);
  assign pmem_write   = serve_b & wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_wmask   = pmem_write ? wmask_q : 2'b00;

  assign resp_a  = serve_a & pmem_resp;
  assign resp_b  = serve_b & pmem_resp;
  assign rdata_a = resp_a ? pmem_rdata : '0;
  assign rdata_b = resp_b ? pmem_rdata : '0;

endmodule
